// File: rtl/acl_cmd_sequencer.sv
// acl_cmd_sequencer
// Turns the tester FSM's level-style ACL2 command strobes into fixed ADXL362
// register-write sequences and hands them to the SPI transaction layer one
// write at a time over a req/done handshake.

module acl_cmd_sequencer #(
    parameter int          RESET_WAIT_CYCLES = 10000,
    parameter logic [10:0] ACT_THRESH        = 11'd336,
    parameter logic [7:0]  ACT_TIME          = 8'd25,
    parameter logic [10:0] INACT_THRESH      = 11'd150,
    parameter logic [15:0] INACT_TIME        = 16'd25
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz_n,
    input  logic       i_acl_cmd_init_measur_mode,
    input  logic       i_acl_cmd_start_measur_mode,
    input  logic       i_acl_cmd_init_linked_mode,
    input  logic       i_acl_cmd_start_linked_mode,
    input  logic       i_acl_cmd_soft_reset,
    output logic       o_acl_command_ready,
    output logic       o_wr_req,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic       i_wr_done
);

    localparam int CW = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        RST_WAIT
    } state_t;

    typedef enum logic [2:0] {
        SEQ_SOFT_RESET,
        SEQ_INIT_MEASUR,
        SEQ_START_MEASUR,
        SEQ_INIT_LINKED,
        SEQ_START_LINKED
    } seq_t;

    state_t          state;
    seq_t            seq;
    logic [3:0]      index;
    logic [CW-1:0]   wait_cnt;
    logic            abort_pending;

    seq_t            cmd_seq;
    logic            cmd_any;
    logic            abort_req;
    logic            abort_now;

    // Register-write table: {addr, data} for entry idx of sequence s
    function automatic logic [15:0] entry(input seq_t s, input logic [3:0] idx);
        logic [15:0] e;
        e = 16'h0000;
        case (s)
            SEQ_SOFT_RESET:   e = {8'h1F, 8'h52};
            SEQ_INIT_MEASUR: begin
                case (idx)
                    4'd0:    e = {8'h2C, 8'h13};
                    4'd1:    e = {8'h2A, 8'h00};
                    default: e = {8'h2B, 8'h00};
                endcase
            end
            SEQ_START_MEASUR: e = {8'h2D, 8'h02};
            SEQ_INIT_LINKED: begin
                case (idx)
                    4'd0:    e = {8'h20, ACT_THRESH[7:0]};
                    4'd1:    e = {8'h21, 5'b00000, ACT_THRESH[10:8]};
                    4'd2:    e = {8'h22, ACT_TIME};
                    4'd3:    e = {8'h23, INACT_THRESH[7:0]};
                    4'd4:    e = {8'h24, 5'b00000, INACT_THRESH[10:8]};
                    4'd5:    e = {8'h25, INACT_TIME[7:0]};
                    4'd6:    e = {8'h26, INACT_TIME[15:8]};
                    4'd7:    e = {8'h27, 8'h3F};
                    default: e = {8'h2B, 8'h40};
                endcase
            end
            SEQ_START_LINKED: e = {8'h2D, 8'h0A};
            default:          e = 16'h0000;
        endcase
        return e;
    endfunction

    // Index of the final write in each sequence
    function automatic logic [3:0] last_index(input seq_t s);
        logic [3:0] l;
        case (s)
            SEQ_INIT_MEASUR: l = 4'd2;
            SEQ_INIT_LINKED: l = 4'd8;
            default:         l = 4'd0;
        endcase
        return l;
    endfunction

    // Pick the highest-priority command level present this cycle
    always_comb begin
        cmd_any = 1'b1;
        cmd_seq = SEQ_SOFT_RESET;
        if (i_acl_cmd_soft_reset)              cmd_seq = SEQ_SOFT_RESET;
        else if (i_acl_cmd_init_measur_mode)   cmd_seq = SEQ_INIT_MEASUR;
        else if (i_acl_cmd_start_measur_mode)  cmd_seq = SEQ_START_MEASUR;
        else if (i_acl_cmd_init_linked_mode)   cmd_seq = SEQ_INIT_LINKED;
        else if (i_acl_cmd_start_linked_mode)  cmd_seq = SEQ_START_LINKED;
        else                                   cmd_any = 1'b0;
    end

    // Soft reset may pre-empt any other sequence, but never itself
    assign abort_req = i_acl_cmd_soft_reset && (seq != SEQ_SOFT_RESET);
    assign abort_now = abort_req || abort_pending;

    // Sequencer FSM with registered handshake and table outputs
    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rst_20mhz_n) begin
            state               <= IDLE;
            seq                 <= SEQ_SOFT_RESET;
            index               <= 4'd0;
            wait_cnt            <= '0;
            abort_pending       <= 1'b0;
            o_acl_command_ready <= 1'b1;
            o_wr_req            <= 1'b0;
            o_wr_addr           <= 8'h00;
            o_wr_data           <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_any) begin
                        seq                    <= cmd_seq;
                        index                  <= 4'd0;
                        abort_pending          <= 1'b0;
                        state                  <= ISSUE;
                        o_acl_command_ready    <= 1'b0;
                        o_wr_req               <= 1'b1;
                        {o_wr_addr, o_wr_data} <= entry(cmd_seq, 4'd0);
                    end
                end
                ISSUE: begin
                    if (i_wr_done) begin
                        o_wr_req      <= 1'b0;
                        abort_pending <= 1'b0;
                        if (abort_now) begin
                            seq   <= SEQ_SOFT_RESET;
                            index <= 4'd0;
                            state <= GAP;
                        end else if (index == last_index(seq)) begin
                            if (seq == SEQ_SOFT_RESET) begin
                                wait_cnt <= '0;
                                state    <= RST_WAIT;
                            end else begin
                                o_acl_command_ready <= 1'b1;
                                state               <= IDLE;
                            end
                        end else begin
                            index <= index + 4'd1;
                            state <= GAP;
                        end
                    end else if (abort_req) begin
                        abort_pending <= 1'b1;
                    end
                end
                GAP: begin
                    state    <= ISSUE;
                    o_wr_req <= 1'b1;
                    if (abort_now) begin
                        seq                    <= SEQ_SOFT_RESET;
                        index                  <= 4'd0;
                        abort_pending          <= 1'b0;
                        {o_wr_addr, o_wr_data} <= entry(SEQ_SOFT_RESET, 4'd0);
                    end else begin
                        {o_wr_addr, o_wr_data} <= entry(seq, index);
                    end
                end
                RST_WAIT: begin
                    if (wait_cnt == CW'(RESET_WAIT_CYCLES - 1)) begin
                        o_acl_command_ready <= 1'b1;
                        state               <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state               <= IDLE;
                    o_acl_command_ready <= 1'b1;
                    o_wr_req            <= 1'b0;
                end
            endcase
        end
    end

endmodule
